rrf_wb_arbiter: RTL and testbench

RRF_WB_ARBITER -- requirements
Module: rrf_wb_arbiter

---
 rtl/rrf_wb_arbiter.sv | 180 ++++++++++++++++++
 tb/tb_rrf_wb_arbiter.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/rrf_wb_arbiter.sv
// Writeback arbiter: three result sources (ALU0, ALU1, LSU) share one RRF write port.
// Define RRF_WB_RR_EN for round-robin arbitration; default build is fixed priority req0 > req1 > req2.

// Small generic FIFO with occupancy count; ready is a pure function of registered count.
// Latency: a pushed entry is visible at the head the cycle after the push edge.
// Backpressure: push_rdy drops when full, even if the head is popped in that same cycle.
module rrf_wb_fifo #(
  parameter int W     = 8,
  parameter int DEPTH = 2,
  parameter int AW    = $clog2(DEPTH),
  parameter int CW    = $clog2(DEPTH) + 1
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          clr,
  input  logic          push_vld,
  input  logic [W-1:0]  push_dat,
  output logic          push_rdy,
  input  logic          pop,
  output logic [W-1:0]  head_dat,
  output logic [CW-1:0] count
);

  localparam logic [CW-1:0] FULL = CW'(DEPTH);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          push;
  logic          do_pop;

  assign push_rdy = (count != FULL);
  assign push     = push_vld && push_rdy && !clr;
  assign do_pop   = pop && (count != '0) && !clr;
  assign head_dat = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= push_dat;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (clr) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push)   wr_ptr <= wr_ptr + 1'b1;
      if (do_pop) rd_ptr <= rd_ptr + 1'b1;
      case ({push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// Arbitrates three per-requester result queues onto one registered RRF write port.
// Latency: result accepted at edge E is written (forward_rrf_we_o) after edge E+1.
// Backpressure: req_ready_o[k] low while queue k is full; kill_i flushes all queues.
module rrf_wb_arbiter #(
  parameter int QDEPTH   = 2,
  parameter int RRF_SEL  = 6,
  parameter int DATA_LEN = 32
) (
  input  logic                  clk_i,
  input  logic                  reset_i,
  input  logic                  kill_i,
  input  logic [2:0]            req_valid_i,
  input  logic [3*RRF_SEL-1:0]  req_rrftag_i,
  input  logic [3*DATA_LEN-1:0] req_data_i,
  output logic [2:0]            req_ready_o,
  output logic                  forward_rrf_we_o,
  output logic [RRF_SEL-1:0]    forward_rrftag_o,
  output logic [DATA_LEN-1:0]   forward_rrfdata_o,
  output logic [2:0]            grant_o
);

  localparam int CW = $clog2(QDEPTH) + 1;
  localparam int EW = RRF_SEL + DATA_LEN;

  typedef struct packed {
    logic [RRF_SEL-1:0]  tag;
    logic [DATA_LEN-1:0] data;
  } entry_t;

  entry_t        head [3];
  entry_t        win_head;
  logic [CW-1:0] count [3];
  logic [2:0]    nonempty;
  logic [2:0]    sel;

  for (genvar k = 0; k < 3; k++) begin : g_q
    entry_t in_ent;
    assign in_ent.tag  = req_rrftag_i[k*RRF_SEL +: RRF_SEL];
    assign in_ent.data = req_data_i[k*DATA_LEN +: DATA_LEN];

    rrf_wb_fifo #(.W(EW), .DEPTH(QDEPTH)) u_fifo (
      .clk      (clk_i),
      .reset_n  (reset_i),
      .clr      (kill_i),
      .push_vld (req_valid_i[k]),
      .push_dat (in_ent),
      .push_rdy (req_ready_o[k]),
      .pop      (sel[k]),
      .head_dat (head[k]),
      .count    (count[k])
    );

    assign nonempty[k] = (count[k] != '0);
  end

  // First non-empty queue in the order a, b, c.
  function automatic logic [2:0] pick3(input logic [2:0] ne, input logic [1:0] a,
                                       input logic [1:0] b, input logic [1:0] c);
    logic [2:0] g;
    g = '0;
    if (ne[a])      g[a] = 1'b1;
    else if (ne[b]) g[b] = 1'b1;
    else if (ne[c]) g[c] = 1'b1;
    return g;
  endfunction

`ifdef RRF_WB_RR_EN
  logic [1:0] last_grant;

  always_comb begin
    sel = '0;
    case (last_grant)
      2'd0:    sel = pick3(nonempty, 2'd1, 2'd2, 2'd0);
      2'd1:    sel = pick3(nonempty, 2'd2, 2'd0, 2'd1);
      default: sel = pick3(nonempty, 2'd0, 2'd1, 2'd2);
    endcase
  end

  always_ff @(posedge clk_i or negedge reset_i) begin
    if (!reset_i) begin
      last_grant <= 2'd2;
    end else if (!kill_i && (sel != '0)) begin
      last_grant <= sel[0] ? 2'd0 : (sel[1] ? 2'd1 : 2'd2);
    end
  end
`else
  always_comb begin
    sel = pick3(nonempty, 2'd0, 2'd1, 2'd2);
  end
`endif

  always_comb begin
    win_head = head[0];
    if (sel[1]) win_head = head[1];
    if (sel[2]) win_head = head[2];
  end

  // Tag/data keep their last written value when idle or flushed.
  always_ff @(posedge clk_i or negedge reset_i) begin
    if (!reset_i) begin
      forward_rrf_we_o  <= 1'b0;
      forward_rrftag_o  <= '0;
      forward_rrfdata_o <= '0;
      grant_o           <= '0;
    end else if (kill_i) begin
      forward_rrf_we_o <= 1'b0;
      grant_o          <= '0;
    end else begin
      forward_rrf_we_o <= (sel != '0);
      grant_o          <= sel;
      if (sel != '0) begin
        forward_rrftag_o  <= win_head.tag;
        forward_rrfdata_o <= win_head.data;
      end
    end
  end

endmodule

// File: tb/tb_rrf_wb_arbiter.sv
// Directed self-checking bench for rrf_wb_arbiter (QDEPTH=2).
module tb_rrf_wb_arbiter;

  localparam int RS = 6;
  localparam int DL = 32;

  logic            clk_i = 1'b0;
  logic            reset_i;
  logic            kill_i;
  logic [2:0]      req_valid_i;
  logic [3*RS-1:0] req_rrftag_i;
  logic [3*DL-1:0] req_data_i;
  logic [2:0]      req_ready_o;
  logic            forward_rrf_we_o;
  logic [RS-1:0]   forward_rrftag_o;
  logic [DL-1:0]   forward_rrfdata_o;
  logic [2:0]      grant_o;

  int checks   = 0;
  int failures = 0;

  logic [2:0]    glog [$];
  logic [RS-1:0] tlog [$];

  rrf_wb_arbiter #(.QDEPTH(2), .RRF_SEL(RS), .DATA_LEN(DL)) dut (
    .clk_i             (clk_i),
    .reset_i           (reset_i),
    .kill_i            (kill_i),
    .req_valid_i       (req_valid_i),
    .req_rrftag_i      (req_rrftag_i),
    .req_data_i        (req_data_i),
    .req_ready_o       (req_ready_o),
    .forward_rrf_we_o  (forward_rrf_we_o),
    .forward_rrftag_o  (forward_rrftag_o),
    .forward_rrfdata_o (forward_rrfdata_o),
    .grant_o           (grant_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  // Advance one edge, sample 1ns later and log any write.
  task automatic tick();
    @(posedge clk_i);
    #1;
    if (forward_rrf_we_o === 1'b1) begin
      glog.push_back(grant_o);
      tlog.push_back(forward_rrftag_o);
    end
  endtask

  task automatic set_req(input int k, input logic [RS-1:0] t, input logic [DL-1:0] d);
    req_rrftag_i[k*RS +: RS] = t;
    req_data_i[k*DL +: DL]   = d;
  endtask

  task automatic do_reset();
    reset_i     = 1'b0;
    kill_i      = 1'b0;
    req_valid_i = '0;
    tick();
    tick();
    reset_i = 1'b1;
    glog.delete();
    tlog.delete();
  endtask

  initial begin
    logic [2:0]    exp_g;
    logic [RS-1:0] t2 [$];
    int            n;

    reset_i      = 1'b0;
    kill_i       = 1'b0;
    req_valid_i  = '0;
    req_rrftag_i = '0;
    req_data_i   = '0;

    // Reset state
    #3;
    check("rst_we",    forward_rrf_we_o, 0);
    check("rst_tag",   forward_rrftag_o, 0);
    check("rst_data",  forward_rrfdata_o, 0);
    check("rst_grant", grant_o, 0);
    check("rst_ready", req_ready_o, 3'b111);
    do_reset();
    check("post_rst_ready", req_ready_o, 3'b111);

    // Single result: accepted at E, written after E+1, idle after E+2 with held tag/data
    req_valid_i = 3'b001;
    set_req(0, 6'd5, 32'hAA);
    tick();
    req_valid_i = '0;
    check("single_lat_we", forward_rrf_we_o, 0);
    tick();
    check("single_we",    forward_rrf_we_o, 1);
    check("single_tag",   forward_rrftag_o, 5);
    check("single_data",  forward_rrfdata_o, 32'hAA);
    check("single_grant", grant_o, 3'b001);
    tick();
    check("single_idle_we",   forward_rrf_we_o, 0);
    check("single_idle_gnt",  grant_o, 0);
    check("single_hold_tag",  forward_rrftag_o, 5);
    check("single_hold_data", forward_rrfdata_o, 32'hAA);

    // Contention: three at once -> three consecutive writes, tags 1,2,3
    do_reset();
    req_valid_i = 3'b111;
    set_req(0, 6'd1, 32'h11);
    set_req(1, 6'd2, 32'h22);
    set_req(2, 6'd3, 32'h33);
    tick();
    req_valid_i = '0;
    repeat (3) tick();
    check("cont_nwr", glog.size(), 3);
    if (glog.size() == 3) begin
      check("cont_t0", tlog[0], 1);
      check("cont_t1", tlog[1], 2);
      check("cont_t2", tlog[2], 3);
      check("cont_g0", glog[0], 3'b001);
      check("cont_g1", glog[1], 3'b010);
      check("cont_g2", glog[2], 3'b100);
    end
    tick();
    check("cont_idle_we", forward_rrf_we_o, 0);

    // Starvation: req0 and req1 continuously valid
    do_reset();
    req_valid_i = 3'b011;
    set_req(0, 6'd10, 32'h100);
    set_req(1, 6'd20, 32'h200);
    tick();
    for (int i = 0; i < 6; i++) begin
      tick();
`ifdef RRF_WB_RR_EN
      exp_g = (i % 2 == 0) ? 3'b001 : 3'b010;
`else
      exp_g = 3'b001;
`endif
      check($sformatf("starve_g%0d", i), grant_o, exp_g);
    end
`ifndef RRF_WB_RR_EN
    check("starve_rdy1", req_ready_o[1], 0);
`endif
    req_valid_i = '0;

    // Full: req2 pushes 7,8,9 back-to-back while req0 keeps priority
    do_reset();
    req_valid_i = 3'b101;
    set_req(0, 6'd1, 32'h1);
    set_req(2, 6'd7, 32'h7);
    tick();
    set_req(2, 6'd8, 32'h8);
    tick();
    check("full_rdy2", req_ready_o[2], 0);
    set_req(2, 6'd9, 32'h9);
    tick();
    req_valid_i = 3'b100;
    n = 0;
    while (req_ready_o[2] !== 1'b1 && n < 20) begin
      tick();
      n++;
    end
    check("full_wait_bound", (n < 20), 1);
    tick();
    req_valid_i = '0;
    repeat (6) tick();
    for (int i = 0; i < glog.size(); i++)
      if (glog[i] == 3'b100) t2.push_back(tlog[i]);
    check("full_n", t2.size(), 3);
    if (t2.size() == 3) begin
      check("full_t0", t2[0], 7);
      check("full_t1", t2[1], 8);
      check("full_t2", t2[2], 9);
    end

    // Flush: two queued entries killed; valid during kill must not enqueue
    do_reset();
    req_valid_i = 3'b011;
    set_req(0, 6'd4, 32'h4);
    set_req(1, 6'd6, 32'h6);
    tick();
    kill_i      = 1'b1;
    req_valid_i = 3'b111;
    set_req(0, 6'd50, 32'h50);
    set_req(1, 6'd51, 32'h51);
    set_req(2, 6'd52, 32'h52);
    tick();
    kill_i      = 1'b0;
    req_valid_i = '0;
    check("kill_we",    forward_rrf_we_o, 0);
    check("kill_grant", grant_o, 0);
    check("kill_ready", req_ready_o, 3'b111);
    repeat (4) tick();
    check("kill_nwr", glog.size(), 0);

    // Async reset mid-cycle while a write is on the port
    do_reset();
    req_valid_i = 3'b001;
    set_req(0, 6'd5, 32'hAA);
    tick();
    req_valid_i = '0;
    tick();
    check("arst_pre_we", forward_rrf_we_o, 1);
    #2;
    reset_i = 1'b0;
    #1;
    check("arst_we",    forward_rrf_we_o, 0);
    check("arst_tag",   forward_rrftag_o, 0);
    check("arst_data",  forward_rrfdata_o, 0);
    check("arst_grant", grant_o, 0);
    check("arst_ready", req_ready_o, 3'b111);
    tick();
    reset_i = 1'b1;
    repeat (3) tick();
    check("arst_no_wr", forward_rrf_we_o, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
